// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, the "no instruction" encoding and the
// default program-counter word type used across the front end.
package cpu_pkg;

    localparam int XLEN         = 32;
    localparam int PC_W_DEFAULT = 30;

    localparam logic [XLEN-1:0] NOP       = 32'h0;
    localparam logic [XLEN-1:0] INST_NONE = 32'h0;

    typedef logic [XLEN-1:0]         inst_t;
    typedef logic [PC_W_DEFAULT-1:0] pc_word_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue holding {pc, instruction} pairs. Flush empties the queue and
// overrides any same-cycle push or pop. The head is read combinationally so a
// pushed entry is visible the cycle after the push.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [PC_W-1:0]          push_pc,
    input  inst_t                    push_inst,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [PC_W-1:0]          head_pc,
    output inst_t                    head_inst
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [PC_W-1:0] pc_mem   [DEPTH];
    inst_t           inst_mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic do_push;
    logic do_pop;
    logic full;

    assign full    = (count_reg == FULL_COUNT);
    assign do_pop  = pop && (count_reg != '0) && !flush;
    // A push into a full queue is only legal when the head leaves in the same
    // cycle; otherwise it is dropped rather than overwriting a live entry.
    assign do_push = push && (!full || do_pop) && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the pushed pair into the entry addressed by the write pointer.
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    pc_mem[gi]   <= push_pc;
                    inst_mem[gi] <= push_inst;
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count      = count_reg;
    assign head_valid = (count_reg != '0);
    assign head_pc    = head_valid ? pc_mem[rd_ptr_reg] : '0;
    assign head_inst  = head_valid ? inst_mem[rd_ptr_reg] : INST_NONE;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads on a shared memory port,
// tracks the single outstanding response and queues returned instructions
// for the decoder. A branch flushes everything and redirects fetch.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 30,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    input  logic              mem_grant,
    output logic [31:0]       mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              branch,
    input  logic [PC_W-1:0]   branch_target,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [PC_W-1:0] fetch_pc_reg;
    logic [PC_W-1:0] inflight_pc_reg;
    logic            inflight_reg;

    logic [CW-1:0]   fifo_count;
    logic [CW:0]     pending;
    logic            accept;
    logic            resp_push;
    logic            pop;

    // Queue slots already claimed: entries held plus the response in flight.
    assign pending   = {1'b0, fifo_count} + (CW+1)'(inflight_reg);
    assign mem_req   = !rst && !branch && (pending < DEPTH_L);
    assign accept    = mem_req && mem_grant;
    // The response arriving this cycle is dropped if a redirect kills it.
    assign resp_push = inflight_reg && !branch && !rst;
    assign pop       = inst_valid && inst_ready;
    assign mem_addr  = 32'({fetch_pc_reg, 2'b00});

    // Fetch PC and outstanding-request tracking; reset beats branch beats fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else if (branch) begin
            fetch_pc_reg    <= branch_target;
            inflight_reg    <= 1'b0;
        end else begin
            inflight_reg <= accept;
            if (accept) begin
                inflight_pc_reg <= fetch_pc_reg;
                fetch_pc_reg    <= fetch_pc_reg + PC_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (resp_push),
        .push_pc    (inflight_pc_reg),
        .push_inst  (mem_rdata),
        .pop        (pop),
        .flush      (branch),
        .count      (fifo_count),
        .head_valid (inst_valid),
        .head_pc    (inst_pc),
        .head_inst  (inst)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, as the prefetch queue entry count (power of two, >= 2).
REQ-002 The block SHALL take parameter PC_W, default 30, as the word-address program-counter width.
REQ-003 The block SHALL take parameter RESET_PC, default 0, as the word address fetched first after reset.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, with synchronous active-high reset.
REQ-006 The block SHALL have port mem_req, output, 1, meaning an instruction read is requested this cycle.
REQ-007 The block SHALL have port mem_grant, input, 1, meaning the shared memory port is free for fetch this cycle (low while a load/store owns it).
REQ-008 The block SHALL have port mem_addr, output, 32, the byte address {fetch_pc, 2'b0}.
REQ-009 The block SHALL have port mem_rdata, input, 32, the read data, valid exactly one cycle after a granted request.
REQ-010 The block SHALL have port branch, input, 1, a redirect/flush strobe.
REQ-011 The block SHALL have port branch_target, input, PC_W, the redirect word address.
REQ-012 The block SHALL have port inst_valid, output, 1, meaning the queue head is valid.
REQ-013 The block SHALL have port inst, output, 32, the head instruction (32'h0 when inst_valid low).
REQ-014 The block SHALL have port inst_pc, output, PC_W, the word address of the head instruction.
REQ-015 The block SHALL have port inst_ready, input, 1, meaning the decoder accepts the head.

Function
REQ-016 A request SHALL be accepted iff mem_req && mem_grant; fetch_pc SHALL increment by 1 on acceptance, wrapping 2^PC_W-1 -> 0.
REQ-017 mem_req SHALL be high iff not rst, not branch, and (occupancy + in-flight) < DEPTH.
REQ-018 In-flight SHALL be 0 or 1; a response SHALL be pushed with its pc in the cycle after acceptance.
REQ-019 Latency: request accepted in cycle N -> inst_valid high in cycle N+2 (no bypass).
REQ-020 A pop SHALL occur iff inst_valid && inst_ready; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-021 Full: when occupancy + in-flight == DEPTH, no request SHALL issue; no entry SHALL ever be overwritten.
REQ-022 Empty: inst_valid SHALL be low and inst SHALL be 32'h0.
REQ-023 On branch: the queue SHALL be cleared, the in-flight response discarded, and fetch_pc loaded with branch_target; the first request SHALL follow in the next cycle.
REQ-024 Branch SHALL win over a same-cycle pop or push.
REQ-025 Back-to-back branches SHALL each reload fetch_pc; the last one wins.
REQ-026 Grant low SHALL stall fetch_pc and leave the queue draining normally.
REQ-027 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 While rst is high at a clock edge: fetch_pc = RESET_PC, occupancy = 0, in-flight = 0, pointers = 0.
REQ-029 Reset SHALL take effect mid-operation, discarding a pending response.
REQ-030 Outputs SHALL be mem_req=0, inst_valid=0, inst=0, inst_pc=0, mem_addr={RESET_PC,2'b0} in the cycle after reset.

Structure
REQ-031 Shared package cpu_pkg SHALL hold XLEN=32, NOP/INST_NONE=32'h0 and the pc word type.
REQ-032 One sub-module, fetch_fifo, SHALL implement the synchronous {pc,inst} queue with count, push, pop and flush.
REQ-033 The fetch_pc, in-flight and discard logic SHALL live in fetch_unit.

Verification
REQ-034 Straight-line test: reset, grant=1, ready=1 -> addresses 0x0, 0x4, 0x8 on consecutive cycles; inst_pc 0, 1, 2 from cycle 2 onward.
REQ-035 Fill test: ready=0, DEPTH=4 -> exactly 4 requests, then mem_req=0; ready=1 -> 4 in-order pops, and fetch resumes.
REQ-036 Grant-stall test: grant=0 for 3 cycles -> mem_addr held and no pushes; no duplicate or skipped pc.
REQ-037 Flush test: branch with target 0x40 while 3 queued and 1 in flight -> inst_valid=0 next cycle; next fetched address 0x100; the stale response is not visible.
REQ-038 Wrap test: PC_W=4, RESET_PC=14 -> pcs 14, 15, 0 queued in order; pointer wrap shows no loss after 2*DEPTH pushes.
REQ-039 Reset test: rst asserted mid-stream -> outputs reach reset values and the first request is at RESET_PC after deassertion.
